approx_adder_error_sweeper: RTL and testbench
=============================================

Name: approx_adder_error_sweeper

Overview:
- Sequential characterisation harness wrapped around a combinational approximate adder netlist (in0..inN / out0..outM style).
- Sits directly upstream of the netlist, drives every input vector in turn, and directly downstream, consuming its outputs.
- Compares each result against the exact sum and accumulates error statistics: max absolute error, sum of absolute errors, threshold-violation count, and worst vector.
- Gives an in-silicon/in-sim pass/fail against the error threshold (ET) for which the netlist was synthesised.

Parameters:
- IN_W, 4, total DUT input bits; two unsigned operands of IN_W/2 bits each; must be even.
- OUT_W, 3, DUT output bits; exact sum is truncated mod 2^OUT_W.
- ET, 5, error threshold; a vector violates when abs error > ET.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a full sweep; sampled only in IDLE or DONE.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when statistics are final.
- dut_in  out  IN_W  registered vector to DUT; bit i drives DUT in<i>.
- dut_out  in  OUT_W  DUT result; bit j comes from DUT out<j>; purely combinational from dut_in.
- max_err  out  OUT_W  largest abs error seen.
- sum_err  out  OUT_W+IN_W  sum of abs errors over all vectors.
- viol_cnt  out  IN_W+1  number of vectors with err > ET.
- worst_vec  out  IN_W  first vector (lowest index) reaching max_err.
- pass  out  1  high when max_err <= ET; valid from done onward.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: rst sampled high at a clk edge forces state IDLE and all outputs (busy, done, dut_in, max_err, sum_err, viol_cnt, worst_vec, pass) to 0.
  - rst has priority over start.
- Operands and arithmetic:
  - a = dut_in[IN_W/2-1:0], b = dut_in[IN_W-1:IN_W/2].
  - exact = (a+b) mod 2^OUT_W.
  - err = |dut_out − exact|, unsigned, OUT_W bits.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 → SWEEP; vec←0; dut_in←0; clear max_err, sum_err, viol_cnt, worst_vec, pass; cap_valid←0.
- SWEEP (stage 1, capture):
  - Each edge: cap_out←dut_out, cap_exact←exact(dut_in), cap_vec←dut_in, cap_valid←1; dut_in←dut_in+1.
  - At the edge capturing vec 2^IN_W−1: dut_in wraps to 0 and state → DRAIN.
- Stage 2, accumulate (any edge with cap_valid=1):
  - sum_err += err.
  - if err > ET: viol_cnt += 1.
  - if err > max_err: max_err←err, worst_vec←cap_vec.
  - Ties keep the earlier vector.
  - If all errors are 0, worst_vec stays 0.
- DRAIN: one cycle; accumulates the last capture; cap_valid←0; → DONE; pass←(final max_err <= ET).
- DONE: done=1 for exactly one cycle; → IDLE unless start=1, in which case → SWEEP (back-to-back restart with stats cleared).
- Latency:
  - Start accepted at edge E0; done high in the cycle following E0+2^IN_W+1 (17 edges for IN_W=4).
  - busy high for 2^IN_W+1 cycles.
- start while busy is ignored, with no queuing.
- Statistics hold after done until the next accepted start or rst.
- rst mid-sweep aborts immediately; no done pulse; all outputs 0.
- No overflow is possible: sum_err max (2^OUT_W−1)·2^IN_W fits OUT_W+IN_W bits; viol_cnt max 2^IN_W fits IN_W+1.

Decomposition:
- Shared package approx_eval_pkg:
  - state enum {IDLE, SWEEP, DRAIN, DONE}.
  - Width helper constants: SUM_W = OUT_W+IN_W, CNT_W = IN_W+1, N_VEC = 2^IN_W.
- One sub-module approx_abs_err: combinational; inputs approx/exact OUT_W; outputs err and viol (err > ET).
- The top holds the FSM, vector counter, capture register and accumulators.

Test Plan:
- Exact 2-bit adder model as DUT, single start → done at edge E0+17, busy 17 cycles; max_err=0, sum_err=0, viol_cnt=0, worst_vec=0, pass=1.
- DUT stub constant 0 → max_err=6, sum_err=48, viol_cnt=1, worst_vec=15 (a=3,b=3), pass=0.
- DUT stub constant 7 → max_err=7, sum_err=64, viol_cnt=3, worst_vec=0, pass=0.
- Exact model, start pulsed again at cycles 5 and 10 of SWEEP → ignored; single done at E0+17; stats identical to the exact case.
- rst=1 at SWEEP cycle 8 → next cycle busy=0, dut_in=0, all stats 0, no done; a subsequent start runs a clean full sweep.
- start held high through DONE → immediate restart, stats cleared on that edge; second done 17 cycles later with identical results.

Source files
------------

// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-adder error sweeper.
//   state_e : sweep controller states.
//   sum_w / cnt_w / n_vec : width helpers derived from the netlist
//   input width (IN_W) and output width (OUT_W).
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of the running sum of absolute errors: (2^OUT_W-1)*2^IN_W fits.
  function automatic int sum_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

  // Width of the violation counter: up to 2^IN_W violations.
  function automatic int cnt_w(input int in_w);
    return in_w + 1;
  endfunction

  // Number of input vectors in one exhaustive sweep.
  function automatic int n_vec(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/approx_abs_err.sv
// Absolute error between an approximate result and the exact result.
//   approx : netlist output (OUT_W bits)
//   exact  : exact sum truncated to OUT_W bits
//   err    : |approx - exact|, unsigned OUT_W bits
//   viol   : err exceeds the error threshold ET
module approx_abs_err #(
  parameter int OUT_W = 3,
  parameter int ET    = 5
) (
  input  logic [OUT_W-1:0] approx,
  input  logic [OUT_W-1:0] exact,
  output logic [OUT_W-1:0] err,
  output logic             viol
);

  localparam logic [31:0] ET_L = ET;

  always_comb begin
    err  = (approx > exact) ? (approx - exact) : (exact - approx);
    viol = (32'(err) > ET_L);
  end

endmodule

// File: rtl/approx_adder_error_sweeper.sv
// Exhaustive error characterisation harness for a combinational
// approximate adder netlist. Drives every input vector in turn,
// compares each netlist result against the exact sum and accumulates
// max / sum of absolute error, threshold violations and worst vector.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : request a sweep (honoured in IDLE or DONE only)
//   busy       : high in SWEEP and DRAIN
//   done       : one-cycle pulse when statistics are final
//   dut_in     : registered vector to the netlist, {b, a}
//   dut_out    : netlist result, combinational from dut_in
//   max_err, sum_err, viol_cnt, worst_vec : accumulated statistics
//   pass       : max_err <= ET, valid from done onward
//
// Pipeline: stage 1 captures {dut_out, exact, dut_in} every SWEEP edge;
// stage 2 folds the capture into the statistics on the following edge.
// DRAIN exists only to fold the final capture in.
module approx_adder_error_sweeper
  import approx_eval_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [IN_W-1:0]                dut_in,
  input  logic [OUT_W-1:0]               dut_out,
  output logic [OUT_W-1:0]               max_err,
  output logic [sum_w(IN_W, OUT_W)-1:0]  sum_err,
  output logic [cnt_w(IN_W)-1:0]         viol_cnt,
  output logic [IN_W-1:0]                worst_vec,
  output logic                           pass
);

  localparam int          SUM_W  = sum_w(IN_W, OUT_W);
  localparam int          CNT_W  = cnt_w(IN_W);
  localparam int          HALF   = IN_W / 2;
  localparam int          WIDE_W = HALF + OUT_W + 1;
  localparam logic [31:0] ET_L   = ET;

  state_e                 state_q, state_d;
  logic [IN_W-1:0]        dut_in_q, dut_in_d;
  logic [OUT_W-1:0]       cap_out_q, cap_out_d;
  logic [OUT_W-1:0]       cap_exact_q, cap_exact_d;
  logic [IN_W-1:0]        cap_vec_q, cap_vec_d;
  logic                   cap_valid_q, cap_valid_d;
  logic [OUT_W-1:0]       max_err_q, max_err_d;
  logic [SUM_W-1:0]       sum_err_q, sum_err_d;
  logic [CNT_W-1:0]       viol_cnt_q, viol_cnt_d;
  logic [IN_W-1:0]        worst_vec_q, worst_vec_d;
  logic                   pass_q, pass_d;

  logic [HALF-1:0]        op_a, op_b;
  logic [WIDE_W-1:0]      sum_wide;
  logic [OUT_W-1:0]       exact_now;
  logic [OUT_W-1:0]       err;
  logic                   viol;
  logic                   launch;

  // Exact sum of the vector currently on dut_in; the wide add keeps the
  // carry so truncation to OUT_W bits is a plain slice for any OUT_W.
  always_comb begin
    op_a      = dut_in_q[HALF-1:0];
    op_b      = dut_in_q[IN_W-1:HALF];
    sum_wide  = WIDE_W'(op_a) + WIDE_W'(op_b);
    exact_now = sum_wide[OUT_W-1:0];
  end

  approx_abs_err #(
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_abs_err (
    .approx (cap_out_q),
    .exact  (cap_exact_q),
    .err    (err),
    .viol   (viol)
  );

  always_comb begin
    state_d     = state_q;
    dut_in_d    = dut_in_q;
    cap_out_d   = cap_out_q;
    cap_exact_d = cap_exact_q;
    cap_vec_d   = cap_vec_q;
    cap_valid_d = cap_valid_q;
    max_err_d   = max_err_q;
    sum_err_d   = sum_err_q;
    viol_cnt_d  = viol_cnt_q;
    worst_vec_d = worst_vec_q;
    pass_d      = pass_q;
    launch      = start && (state_q == IDLE || state_q == DONE);

    // Stage 2: fold the previous capture into the statistics. Strict '>'
    // keeps the lowest-index vector on ties.
    if (cap_valid_q) begin
      sum_err_d = sum_err_q + SUM_W'(err);
      if (viol) viol_cnt_d = viol_cnt_q + CNT_W'(1);
      if (err > max_err_q) begin
        max_err_d   = err;
        worst_vec_d = cap_vec_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
      end
      SWEEP: begin
        cap_out_d   = dut_out;
        cap_exact_d = exact_now;
        cap_vec_d   = dut_in_q;
        cap_valid_d = 1'b1;
        dut_in_d    = dut_in_q + IN_W'(1);
        if (dut_in_q == '1) state_d = DRAIN;
      end
      DRAIN: begin
        cap_valid_d = 1'b0;
        pass_d      = (32'(max_err_d) <= ET_L);
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A new sweep clears everything on its accepting edge.
    if (launch) begin
      state_d     = SWEEP;
      dut_in_d    = '0;
      cap_valid_d = 1'b0;
      max_err_d   = '0;
      sum_err_d   = '0;
      viol_cnt_d  = '0;
      worst_vec_d = '0;
      pass_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dut_in_q    <= '0;
      cap_out_q   <= '0;
      cap_exact_q <= '0;
      cap_vec_q   <= '0;
      cap_valid_q <= 1'b0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
      viol_cnt_q  <= '0;
      worst_vec_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dut_in_q    <= dut_in_d;
      cap_out_q   <= cap_out_d;
      cap_exact_q <= cap_exact_d;
      cap_vec_q   <= cap_vec_d;
      cap_valid_q <= cap_valid_d;
      max_err_q   <= max_err_d;
      sum_err_q   <= sum_err_d;
      viol_cnt_q  <= viol_cnt_d;
      worst_vec_q <= worst_vec_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dut_in    = dut_in_q;
  assign max_err   = max_err_q;
  assign sum_err   = sum_err_q;
  assign viol_cnt  = viol_cnt_q;
  assign worst_vec = worst_vec_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Bench for approx_adder_error_sweeper with a selectable netlist model:
//   mode 0 exact 2-bit adder, 1 constant 0, 2 constant 7, 3 constant 3.
module tb_approx_adder_error_sweeper;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int ET    = 5;
  localparam int ST_W  = 20;  // {max_err 3, sum_err 7, viol_cnt 5, worst_vec 4, pass 1}

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [OUT_W-1:0] max_err;
  logic [6:0]       sum_err;
  logic [4:0]       viol_cnt;
  logic [IN_W-1:0]  worst_vec;
  logic             pass;
  int               mode;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ST_W-1:0] exp_q[$];

  typedef struct {
    string      name;
    int         mode;
    int         extra_start;
    logic [2:0] max_err;
    logic [6:0] sum_err;
    logic [4:0] viol;
    logic [3:0] worst;
    logic       pass;
  } vec_t;

  vec_t tbl[5];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  approx_adder_error_sweeper #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .max_err   (max_err),
    .sum_err   (sum_err),
    .viol_cnt  (viol_cnt),
    .worst_vec (worst_vec),
    .pass      (pass)
  );

  // Netlist models
  always_comb begin
    dut_out = '0;
    case (mode)
      0: dut_out = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
      1: dut_out = 3'd0;
      2: dut_out = 3'd7;
      3: dut_out = 3'd3;
      default: dut_out = '0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_exp(input vec_t v);
    exp_q.push_back({v.max_err, v.sum_err, v.viol, v.worst, v.pass});
  endtask

  task automatic check_stats(input string nm);
    logic [ST_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({nm, " exp_q empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({nm, " max_err"},   32'(max_err),   32'(e[19:17]));
      check({nm, " sum_err"},   32'(sum_err),   32'(e[16:10]));
      check({nm, " viol_cnt"},  32'(viol_cnt),  32'(e[9:5]));
      check({nm, " worst_vec"}, 32'(worst_vec), 32'(e[4:1]));
      check({nm, " pass"},      32'(pass),      32'(e[0]));
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, " busy"},      32'(busy),      32'd0);
    check({nm, " done"},      32'(done),      32'd0);
    check({nm, " dut_in"},    32'(dut_in),    32'd0);
    check({nm, " max_err"},   32'(max_err),   32'd0);
    check({nm, " sum_err"},   32'(sum_err),   32'd0);
    check({nm, " viol_cnt"},  32'(viol_cnt),  32'd0);
    check({nm, " worst_vec"}, 32'(worst_vec), 32'd0);
    check({nm, " pass"},      32'(pass),      32'd0);
  endtask

  // One sweep from a start pulse; checks done timing, busy length,
  // single done pulse, and statistics (which must hold after done).
  task automatic run_sweep(input vec_t v);
    int done_at, done_cnt, busy_cnt;
    mode = v.mode;
    push_exp(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    done_at  = 0;
    done_cnt = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 25; k++) begin
      start = (v.extra_start != 0) && (k == 5 || k == 10);
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
    check({v.name, " done edge"},  32'(done_at),  32'd17);
    check({v.name, " done count"}, 32'(done_cnt), 32'd1);
    check({v.name, " busy cycles"}, 32'(busy_cnt), 32'd17);
    check_stats(v.name);
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0] = '{"exact",       0, 0, 3'd0, 7'd0,  5'd0, 4'd0,  1'b1};
    tbl[1] = '{"const0",      1, 0, 3'd6, 7'd48, 5'd1, 4'd15, 1'b0};
    tbl[2] = '{"const7",      2, 0, 3'd7, 7'd64, 5'd3, 4'd0,  1'b0};
    tbl[3] = '{"const3",      3, 0, 3'd3, 7'd20, 5'd0, 4'd0,  1'b1};
    tbl[4] = '{"exact_extra", 0, 1, 3'd0, 7'd0,  5'd0, 4'd0,  1'b1};

    mode  = 0;
    rst   = 1'b1;
    start = 1'b1;  // reset must win over start
    tick();
    tick();
    check_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

    // Mid-sweep reset: abort, everything zero, no done pulse afterwards.
    begin
      int done_cnt;
      mode  = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("pre-abort busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("abort");
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (done || busy) done_cnt++;
      end
      check("abort idle activity", 32'(done_cnt), 32'd0);
      run_sweep(tbl[1]);
    end

    // start held through DONE: immediate restart with stats cleared.
    begin
      int done_at;
      mode = 2;
      push_exp(tbl[2]);
      start = 1'b1;
      tick();
      done_at = 0;
      for (int k = 1; k <= 25 && done_at == 0; k++) begin
        tick();
        if (done) done_at = k;
      end
      check("b2b first done edge", 32'(done_at), 32'd17);
      check_stats("b2b first");
      tick();
      check("b2b restart busy", 32'(busy), 32'd1);
      check("b2b restart done", 32'(done), 32'd0);
      check("b2b cleared sum_err", 32'(sum_err), 32'd0);
      check("b2b cleared max_err", 32'(max_err), 32'd0);
      check("b2b cleared viol_cnt", 32'(viol_cnt), 32'd0);
      check("b2b cleared pass", 32'(pass), 32'd0);
      start = 1'b0;
      push_exp(tbl[2]);
      done_at = 0;
      for (int k = 1; k <= 25 && done_at == 0; k++) begin
        tick();
        if (done) done_at = k;
      end
      check("b2b second done edge", 32'(done_at), 32'd17);
      check_stats("b2b second");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
